// File: rtl/sm4_request_arbiter.sv
// Round-robin front end sharing one sm4_encryptor core among NUM_REQ requesters.
// In-order tag FIFO routes results to their owners; flush drains then invalidates the key cache.
module sm4_request_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int OUT_DEPTH = 4
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic [NUM_REQ*128-1:0]         req_content_i,
   input  logic [NUM_REQ*128-1:0]         req_key_i,
   input  logic [NUM_REQ-1:0]             req_encode_or_decode_i,
   input  logic [NUM_REQ-1:0]             req_v_i,
   output logic [NUM_REQ-1:0]             req_ready_o,
   output logic [127:0]                   resp_crypt_o,
   output logic [NUM_REQ-1:0]             resp_v_o,
   input  logic [NUM_REQ-1:0]             resp_yumi_i,
   input  logic                           flush_req_i,
   output logic                           flush_done_o,
   output logic [127:0]                   core_content_o,
   output logic [127:0]                   core_key_o,
   output logic                           core_encode_or_decode_o,
   output logic                           core_v_o,
   input  logic                           core_ready_i,
   input  logic [127:0]                   core_crypt_i,
   input  logic                           core_v_i,
   output logic                           core_yumi_o,
   output logic                           core_invalid_cache_o,
   output logic [$clog2(OUT_DEPTH+1)-1:0] outstanding_o
);

   localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CW = $clog2(OUT_DEPTH+1);

   typedef enum logic [1:0] {RUN, DRAIN, INVAL} state_e;

   state_e                       state_q, state_d;
   logic [RW-1:0]                rr_q, g, h;
   logic [OUT_DEPTH-1:0][RW-1:0] tag_q;
   logic [PW-1:0]                wr_q, rd_q;
   logic [CW-1:0]                cnt_q;
   logic                         full, empty, found, fire, pop;
   int                           idx;

   assign full  = (cnt_q == CW'(OUT_DEPTH));
   assign empty = (cnt_q == '0);
   assign h     = tag_q[rd_q];

   // first valid requester at or after the rr pointer, wrapping
   always_comb begin
      g     = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_v_i[RW'(idx)]) begin
            g     = RW'(idx);
            found = 1'b1;
         end
      end
   end

   // reset_n_i gates the issue path so outputs drop asynchronously
   assign core_v_o    = reset_n_i && (state_q == RUN) && found && !full;
   assign fire        = core_v_o && core_ready_i;
   assign req_ready_o = fire ? (NUM_REQ'(1) << g) : '0;

   assign core_content_o          = core_v_o ? req_content_i[int'(g)*128 +: 128] : req_content_i[127:0];
   assign core_key_o              = core_v_o ? req_key_i[int'(g)*128 +: 128]     : req_key_i[127:0];
   assign core_encode_or_decode_o = core_v_o ? req_encode_or_decode_i[g]          : req_encode_or_decode_i[0];

   assign resp_crypt_o = core_crypt_i;
   assign resp_v_o     = (core_v_i && !empty) ? (NUM_REQ'(1) << h) : '0;
   assign core_yumi_o  = core_v_i && !empty && resp_yumi_i[h];
   assign pop          = core_yumi_o;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         tag_q <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         rr_q  <= '0;
      end else begin
         if (fire) begin
            tag_q[wr_q] <= g;
            wr_q        <= wr_q + PW'(1);
            rr_q        <= (g == RW'(NUM_REQ-1)) ? '0 : g + RW'(1);
         end
         if (pop) rd_q <= rd_q + PW'(1);
         case ({fire, pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign outstanding_o = cnt_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state_q <= RUN;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d              = state_q;
      core_invalid_cache_o = 1'b0;
      flush_done_o         = 1'b0;
      case (state_q)
         RUN:     if (flush_req_i) state_d = DRAIN;
         DRAIN:   if (cnt_q == '0 && !fire) state_d = INVAL;
         INVAL: begin
            core_invalid_cache_o = 1'b1;
            flush_done_o         = 1'b1;
            state_d              = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // a core result with no tag in flight means the core and arbiter disagree
   a_no_orphan_resp: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(core_v_i && empty));

endmodule

// File: tb/tb_sm4_request_arbiter.sv
// Directed vector bench for sm4_request_arbiter; the core side is driven directly by the bench.
module tb_sm4_request_arbiter;
   localparam int N = 4;
   localparam int D = 4;
   localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n;
   logic [N*128-1:0] req_content, req_key;
   logic [N-1:0]   req_mode, req_v, req_ready, resp_v, resp_yumi;
   logic [127:0]   resp_crypt, core_content, core_key, core_crypt;
   logic           flush_req, flush_done, core_mode, core_v_o, core_ready, core_v_i;
   logic           core_yumi, core_inval;
   logic [2:0]     outstanding;

   sm4_request_arbiter #(.NUM_REQ(N), .OUT_DEPTH(D)) dut (
      .clk_i(clk), .reset_n_i(rst_n),
      .req_content_i(req_content), .req_key_i(req_key), .req_encode_or_decode_i(req_mode),
      .req_v_i(req_v), .req_ready_o(req_ready),
      .resp_crypt_o(resp_crypt), .resp_v_o(resp_v), .resp_yumi_i(resp_yumi),
      .flush_req_i(flush_req), .flush_done_o(flush_done),
      .core_content_o(core_content), .core_key_o(core_key), .core_encode_or_decode_o(core_mode),
      .core_v_o(core_v_o), .core_ready_i(core_ready), .core_crypt_i(core_crypt),
      .core_v_i(core_v_i), .core_yumi_o(core_yumi), .core_invalid_cache_o(core_inval),
      .outstanding_o(outstanding)
   );

   typedef struct {
      logic [3:0] rv, ry;
      logic [2:0] ctl;   // {core_ready, core_v, flush}
      logic [3:0] rdy, rsp;
      logic [3:0] o;     // {core_v_o, core_yumi, invalidate, done}
      logic [2:0] outs;
      int         g;     // requester whose data must appear on the core bus
   } vec_t;

   vec_t          tbl[$];
   int            errors = 0;
   int            checks = 0;
   logic [127:0]  key_a[N];
   logic [127:0]  txt_a[N];

   function automatic void add(input logic [3:0] rv, input logic [3:0] ry, input logic [2:0] ctl,
                               input logic [3:0] rdy, input logic [3:0] rsp, input logic [3:0] o,
                               input logic [2:0] outs, input int g);
      vec_t v;
      v.rv = rv; v.ry = ry; v.ctl = ctl; v.rdy = rdy; v.rsp = rsp; v.o = o; v.outs = outs; v.g = g;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_all(input string p, input logic [3:0] rdy, input logic [3:0] rsp,
                            input logic [3:0] o, input logic [2:0] outs, input int g);
      chk({p, " req_ready"}, 128'(req_ready), 128'(rdy));
      chk({p, " resp_v"},    128'(resp_v),    128'(rsp));
      chk({p, " core_v"},    128'(core_v_o),  128'(o[3]));
      chk({p, " core_yumi"}, 128'(core_yumi), 128'(o[2]));
      chk({p, " inval"},     128'(core_inval), 128'(o[1]));
      chk({p, " done"},      128'(flush_done), 128'(o[0]));
      chk({p, " outstanding"}, 128'(outstanding), 128'(outs));
      chk({p, " core_key"},  core_key, key_a[g]);
      chk({p, " core_content"}, core_content, txt_a[g]);
      chk({p, " core_mode"}, 128'(core_mode), 128'(req_mode[g]));
      chk({p, " resp_crypt"}, resp_crypt, core_crypt);
   endtask

   initial begin
      for (int r = 0; r < N; r++) begin
         key_a[r] = (r == 2) ? KEY : KEY ^ (128'(r + 1) << 100);
         txt_a[r] = (r == 2) ? KEY : ~KEY ^ 128'(r);
         req_key[r*128 +: 128]     = key_a[r];
         req_content[r*128 +: 128] = txt_a[r];
      end
      req_mode = 4'b1010;

      // round robin fill to full, wrong-bit yumi, in-order drain
      add(4'b1111, 4'b0000, 3'b100, 4'b0001, 4'b0000, 4'b1000, 3'd0, 0);
      add(4'b1111, 4'b0000, 3'b100, 4'b0010, 4'b0000, 4'b1000, 3'd1, 1);
      add(4'b1111, 4'b0000, 3'b100, 4'b0100, 4'b0000, 4'b1000, 3'd2, 2);
      add(4'b1111, 4'b0000, 3'b100, 4'b1000, 4'b0000, 4'b1000, 3'd3, 3);
      add(4'b1111, 4'b0000, 3'b100, 4'b0000, 4'b0000, 4'b0000, 3'd4, 0);
      add(4'b1111, 4'b0010, 3'b110, 4'b0000, 4'b0001, 4'b0000, 3'd4, 0);
      add(4'b1111, 4'b0001, 3'b110, 4'b0000, 4'b0001, 4'b0100, 3'd4, 0);
      add(4'b1111, 4'b0000, 3'b100, 4'b0001, 4'b0000, 4'b1000, 3'd3, 0);
      add(4'b0000, 4'b1111, 3'b110, 4'b0000, 4'b0010, 4'b0100, 3'd4, 0);
      add(4'b0000, 4'b0100, 3'b110, 4'b0000, 4'b0100, 4'b0100, 3'd3, 0);
      add(4'b0000, 4'b1000, 3'b110, 4'b0000, 4'b1000, 4'b0100, 3'd2, 0);
      add(4'b0000, 4'b0001, 3'b110, 4'b0000, 4'b0001, 4'b0100, 3'd1, 0);
      add(4'b0000, 4'b0000, 3'b100, 4'b0000, 4'b0000, 4'b0000, 3'd0, 0);
      // single request from requester 2
      add(4'b0100, 4'b0000, 3'b100, 4'b0100, 4'b0000, 4'b1000, 3'd0, 2);
      add(4'b0000, 4'b0000, 3'b110, 4'b0000, 4'b0100, 4'b0000, 3'd1, 0);
      add(4'b0000, 4'b0100, 3'b110, 4'b0000, 4'b0100, 4'b0100, 3'd1, 0);
      add(4'b0000, 4'b0000, 3'b100, 4'b0000, 4'b0000, 4'b0000, 3'd0, 0);
      // core not ready holds the pointer; wrap search from 3
      add(4'b0001, 4'b0000, 3'b000, 4'b0000, 4'b0000, 4'b1000, 3'd0, 0);
      add(4'b0011, 4'b0000, 3'b100, 4'b0001, 4'b0000, 4'b1000, 3'd0, 0);
      add(4'b0011, 4'b0000, 3'b100, 4'b0010, 4'b0000, 4'b1000, 3'd1, 1);
      add(4'b0001, 4'b0000, 3'b100, 4'b0001, 4'b0000, 4'b1000, 3'd2, 0);
      // flush with issue in the sample cycle, drain 4, invalidate, resume
      add(4'b1111, 4'b0000, 3'b101, 4'b0010, 4'b0000, 4'b1000, 3'd3, 1);
      add(4'b1111, 4'b0000, 3'b100, 4'b0000, 4'b0000, 4'b0000, 3'd4, 0);
      add(4'b1111, 4'b0001, 3'b110, 4'b0000, 4'b0001, 4'b0100, 3'd4, 0);
      add(4'b1111, 4'b0010, 3'b110, 4'b0000, 4'b0010, 4'b0100, 3'd3, 0);
      add(4'b1111, 4'b0001, 3'b110, 4'b0000, 4'b0001, 4'b0100, 3'd2, 0);
      add(4'b1111, 4'b0010, 3'b110, 4'b0000, 4'b0010, 4'b0100, 3'd1, 0);
      add(4'b1111, 4'b0000, 3'b100, 4'b0000, 4'b0000, 4'b0000, 3'd0, 0);
      add(4'b1111, 4'b0000, 3'b100, 4'b0000, 4'b0000, 4'b0011, 3'd0, 0);
      add(4'b1111, 4'b0000, 3'b100, 4'b0100, 4'b0000, 4'b1000, 3'd0, 2);
      add(4'b0000, 4'b0100, 3'b110, 4'b0000, 4'b0100, 4'b0100, 3'd1, 0);
      // flush from empty with flush held high: back-to-back flushes
      add(4'b0000, 4'b0000, 3'b101, 4'b0000, 4'b0000, 4'b0000, 3'd0, 0);
      add(4'b1111, 4'b0000, 3'b101, 4'b0000, 4'b0000, 4'b0000, 3'd0, 0);
      add(4'b1111, 4'b0000, 3'b101, 4'b0000, 4'b0000, 4'b0011, 3'd0, 0);
      add(4'b1111, 4'b0000, 3'b101, 4'b1000, 4'b0000, 4'b1000, 3'd0, 3);
      add(4'b1111, 4'b0000, 3'b100, 4'b0000, 4'b0000, 4'b0000, 3'd1, 0);
      add(4'b0000, 4'b1000, 3'b110, 4'b0000, 4'b1000, 4'b0100, 3'd1, 0);
      add(4'b0000, 4'b0000, 3'b100, 4'b0000, 4'b0000, 4'b0000, 3'd0, 0);
      add(4'b0000, 4'b0000, 3'b100, 4'b0000, 4'b0000, 4'b0011, 3'd0, 0);
      add(4'b0000, 4'b0000, 3'b100, 4'b0000, 4'b0000, 4'b0000, 3'd0, 0);

      // reset state with busy inputs
      rst_n = 1'b0; req_v = 4'b1111; resp_yumi = 4'b1111; core_ready = 1'b1;
      core_v_i = 1'b1; flush_req = 1'b1; core_crypt = CT;
      #3;
      check_all("reset", 4'b0000, 4'b0000, 4'b0000, 3'd0, 0);
      @(negedge clk);
      @(negedge clk);
      req_v = '0; resp_yumi = '0; core_v_i = 1'b0; flush_req = 1'b0; rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         req_v      = tbl[i].rv;
         resp_yumi  = tbl[i].ry;
         core_ready = tbl[i].ctl[2];
         core_v_i   = tbl[i].ctl[1];
         flush_req  = tbl[i].ctl[0];
         core_crypt = CT ^ 128'(i);
         #1;
         check_all($sformatf("v%0d", i), tbl[i].rdy, tbl[i].rsp, tbl[i].o, tbl[i].outs, tbl[i].g);
      end

      // async reset with two outstanding and requests pending
      @(negedge clk);
      req_v = 4'b0011; resp_yumi = '0; core_ready = 1'b1; core_v_i = 1'b0; flush_req = 1'b0;
      #1;
      check_all("pre0", 4'b0001, 4'b0000, 4'b1000, 3'd0, 0);
      @(negedge clk);
      #1;
      check_all("pre1", 4'b0010, 4'b0000, 4'b1000, 3'd1, 1);
      @(negedge clk);
      req_v = 4'b1111;
      #1;
      check_all("pre2", 4'b0100, 4'b0000, 4'b1000, 3'd2, 2);
      rst_n = 1'b0; core_v_i = 1'b1; resp_yumi = 4'b1111;
      #1;
      check_all("async_rst", 4'b0000, 4'b0000, 4'b0000, 3'd0, 0);
      @(posedge clk);
      @(negedge clk);
      core_v_i = 1'b0; resp_yumi = '0; rst_n = 1'b1;
      #1;
      check_all("post_rst0", 4'b0001, 4'b0000, 4'b1000, 3'd0, 0);
      @(negedge clk);
      #1;
      check_all("post_rst1", 4'b0010, 4'b0000, 4'b1000, 3'd1, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sm4_request_arbiter.md
Name: sm4_request_arbiter

Overview:
Shares one sm4_encryptor core between NUM_REQ independent requesters. Each requester has its own valid/ready request channel and valid/yumi response channel.
- Requests are granted round-robin and issued to the core.
- Requester IDs of in-flight operations are held in an in-order tag FIFO, which routes core results back to their owners.
- A flush sequencer drains all outstanding work, then pulses the core's key-cache invalidate.
- Sits between the requester fabric and the sm4_encryptor core ports.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
OUT_DEPTH, 4, maximum operations outstanding in the core (tag FIFO depth, power of 2)

Ports:
clk_i  in  1  clock; all state updates on rising edge
reset_n_i  in  1  asynchronous, active-low reset
req_content_i  in  NUM_REQ*128  per-requester plaintext/ciphertext, requester r at bits [r*128 +: 128]
req_key_i  in  NUM_REQ*128  per-requester key, same packing
req_encode_or_decode_i  in  NUM_REQ  per-requester mode bit
req_v_i  in  NUM_REQ  request valid
req_ready_o  out  NUM_REQ  one-hot request accept (this-cycle handshake)
resp_crypt_o  out  128  result data, shared by all requesters
resp_v_o  out  NUM_REQ  one-hot response valid for the owning requester
resp_yumi_i  in  NUM_REQ  response consume
flush_req_i  in  1  request drain plus cache invalidate (level; sampled in RUN only)
flush_done_o  out  1  one-cycle pulse when flush completes
core_content_o  out  128  to core content_i
core_key_o  out  128  to core key_i
core_encode_or_decode_o  out  1  to core encode_or_decode_i
core_v_o  out  1  to core v_i
core_ready_i  in  1  from core ready_o
core_crypt_i  in  128  from core crypt_o
core_v_i  in  1  from core v_o
core_yumi_o  out  1  to core yumi_i
core_invalid_cache_o  out  1  to core invalid_cache_i
outstanding_o  out  $clog2(OUT_DEPTH+1)  number of in-flight operations

Behaviour:
Reset (async, reset_n_i=0):
- State=RUN, rr pointer=0, tag FIFO empty, outstanding_o=0.
- All outputs are 0: req_ready_o, resp_v_o, core_v_o, core_yumi_o, core_invalid_cache_o, flush_done_o.
- Reset mid-operation discards all tags. The core is reset by the same system reset; no completion is reported for discarded operations.

Grant:
- Combinational. g = first r with req_v_i[r]=1, searching from rr pointer upward modulo NUM_REQ.
- core_v_o = (state==RUN) & |req_v_i & !fifo_full.
- core data/key/mode outputs mux requester g. They are don't-care (drive requester 0) when core_v_o=0.

Issue fire:
- Fires when core_v_o & core_ready_i.
- req_ready_o[g]=1 that cycle only.
- g is pushed into the tag FIFO.
- rr pointer <= (g+1) mod NUM_REQ.
- rr pointer is unchanged when there is no fire.
- No requester waits more than NUM_REQ-1 fires while continuously valid.

Response:
- h = tag FIFO head.
- resp_v_o[h] = core_v_i & !fifo_empty.
- resp_crypt_o = core_crypt_i.
- core_yumi_o = core_v_i & resp_yumi_i[h] & !fifo_empty.
- The FIFO pops on core_yumi_o.
- resp_yumi_i bits other than h are ignored.
- core_v_i with an empty FIFO is an error: core_yumi_o stays 0 and an assertion must fire.

FIFO full/empty and outstanding count:
- Push is blocked when full, even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: count is unchanged, pointers wrap mod OUT_DEPTH.
- outstanding_o = FIFO count, registered.

Flush FSM (RUN -> DRAIN -> INVAL -> RUN):
- RUN: flush_req_i=1 -> DRAIN. Grants are suppressed from the next cycle onward; an issue firing in the same cycle flush is sampled still completes.
- DRAIN: core_v_o=0; responses continue. When outstanding_o==0 and no push is pending -> INVAL. If already empty at entry, DRAIN lasts exactly 1 cycle.
- INVAL: core_invalid_cache_o=1 for exactly 1 cycle -> RUN, with flush_done_o=1 in that same INVAL cycle.
- flush_req_i is ignored outside RUN. If still high on return to RUN, a new flush starts the next cycle.

Latency: issue is combinational through the arbiter (0 added cycles). Responses have 0 added cycles.

Test Plan:
- Single request: req 2 valid, core ready, key=0x0123456789abcdeffedcba9876543210, content=same, encode -> req_ready_o=4'b0100 for 1 cycle; core_key_o matches; later resp_v_o=4'b0100 with crypt 0x681edf34d206965e86b3e94f536e4246; yumi pops; outstanding_o returns to 0.
- All four requesters valid continuously, core always ready, OUT_DEPTH=4 -> grant order 0,1,2,3,0; fifth grant waits for first pop (fifo full); rr pointer wraps.
- Responses returned for tags 1,3,0 -> resp_v_o one-hot 0010, 1000, 0001 in order; resp_yumi_i asserted on the wrong bit -> no pop, core_yumi_o=0.
- Flush with 3 outstanding -> core_v_o held 0; after 3 yumis, core_invalid_cache_o and flush_done_o pulse exactly 1 cycle; grants resume the next cycle.
- Flush with FIFO empty -> DRAIN 1 cycle, INVAL 1 cycle, done at cycle 2 after sample; flush_req_i held high -> second flush begins immediately.
- reset_n_i dropped with 2 outstanding and requests pending -> all outputs 0 asynchronously, outstanding_o=0; after release, grant starts at requester 0.
